// File: rtl/id_ex_ctrl_if.sv
// IF/ID -> ID/EX control bundle interface.
// master: the pipeline side presenting the instruction and taking the controls.
// slave: the id_ex_ctrl stage itself.
interface id_ex_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) ();
  logic             in_valid;
  logic [31:0]      inst;
  logic [XLEN-1:0]  in_pc;
  logic             flush;
  logic             ex_stall;
  logic             stall_if;
  logic             out_valid;
  logic [XLEN-1:0]  out_pc;
  logic [4:0]       rs1, rs2, rd;
  logic             rs1_re, rs2_re;
  logic             reg_we;
  logic [1:0]       wb_sel;
  logic [1:0]       pc_sel;
  logic             branch;
  logic             mem_re, mem_we;
  logic [1:0]       mem_size;
  logic             mem_unsigned;
  logic [3:0]       alu_ctrl;
  logic             op_a_sel, op_b_sel;
  logic [2:0]       sext_op;
  logic             illegal;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output in_valid, inst, in_pc, flush, ex_stall,
    input  stall_if, out_valid, out_pc, rs1, rs2, rd, rs1_re, rs2_re, reg_we,
           wb_sel, pc_sel, branch, mem_re, mem_we, mem_size, mem_unsigned,
           alu_ctrl, op_a_sel, op_b_sel, sext_op, illegal, bubble_cnt
  );

  modport slave (
    input  in_valid, inst, in_pc, flush, ex_stall,
    output stall_if, out_valid, out_pc, rs1, rs2, rd, rs1_re, rs2_re, reg_we,
           wb_sel, pc_sel, branch, mem_re, mem_we, mem_size, mem_unsigned,
           alu_ctrl, op_a_sel, op_b_sel, sext_op, illegal, bubble_cnt
  );
endinterface

// File: rtl/id_ex_ctrl.sv
// RV32I decoder with registered ID/EX control bundle, load-use bubble
// insertion, flush and downstream hold.
module id_ex_ctrl #(
  parameter int XLEN            = 32,
  parameter bit LOAD_USE_DETECT = 1'b1,
  parameter int CNT_W           = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_ctrl_if.slave  bus
);
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rs1_re;
    logic       rs2_re;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic [1:0] pc_sel;
    logic       branch;
    logic       mem_re;
    logic       mem_we;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic [3:0] alu_ctrl;
    logic       op_a_sel;
    logic       op_b_sel;
    logic [2:0] sext_op;
    logic       illegal;
  } ctrl_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  ctrl_t            r_ctrl;
  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_pc;
  logic [CNT_W-1:0] r_bubble_cnt;

  ctrl_t            w_dec;
  ctrl_t            w_load;
  logic [6:0]       w_opc;
  logic [2:0]       w_f3;
  logic             w_alt;
  logic             w_hazard;
  logic             w_unused;

  assign w_opc = bus.inst[6:0];
  assign w_f3  = bus.inst[14:12];
  assign w_alt = bus.inst[30];
  // Bits only meaningful to the immediate generator downstream.
  assign w_unused = &{1'b0, bus.inst[31], bus.inst[29:25]};

  // ALU op for register/immediate arithmetic; alt selects sub/sra.
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_of = alt ? 4'b0001 : 4'b0000;
      3'b001:  alu_of = 4'b0101;
      3'b010:  alu_of = 4'b1000;
      3'b011:  alu_of = 4'b1001;
      3'b100:  alu_of = 4'b0100;
      3'b101:  alu_of = alt ? 4'b0111 : 4'b0110;
      3'b110:  alu_of = 4'b0011;
      default: alu_of = 4'b0010;
    endcase
  endfunction

  // Combinational decode of the IF/ID instruction.
  always_comb begin
    w_dec     = '0;
    w_dec.rs1 = bus.inst[19:15];
    w_dec.rs2 = bus.inst[24:20];
    w_dec.rd  = bus.inst[11:7];
    case (w_opc)
      OP_LUI: begin
        w_dec.reg_we = 1'b1; w_dec.wb_sel = 2'b11; w_dec.sext_op = 3'b100;
      end
      OP_AUIPC: begin
        w_dec.reg_we = 1'b1; w_dec.op_a_sel = 1'b1; w_dec.sext_op = 3'b100;
      end
      OP_JAL: begin
        w_dec.reg_we = 1'b1; w_dec.wb_sel = 2'b01; w_dec.pc_sel = 2'b01;
        w_dec.branch = 1'b1; w_dec.sext_op = 3'b101;
      end
      OP_JALR: begin
        w_dec.reg_we = 1'b1; w_dec.wb_sel = 2'b01; w_dec.pc_sel = 2'b10;
        w_dec.branch = 1'b1; w_dec.sext_op = 3'b001; w_dec.rs1_re = 1'b1;
        w_dec.illegal = (w_f3 != 3'b000);
      end
      OP_BRANCH: begin
        w_dec.pc_sel = 2'b11; w_dec.branch = 1'b1; w_dec.sext_op = 3'b011;
        w_dec.rs1_re = 1'b1; w_dec.rs2_re = 1'b1; w_dec.op_b_sel = 1'b1;
        w_dec.alu_ctrl = w_f3[2] ? {2'b11, w_f3[1:0]} : {3'b101, w_f3[0]};
        w_dec.illegal = (w_f3[2:1] == 2'b01);
      end
      OP_LOAD: begin
        w_dec.reg_we = 1'b1; w_dec.mem_re = 1'b1; w_dec.wb_sel = 2'b10;
        w_dec.sext_op = 3'b001; w_dec.rs1_re = 1'b1;
        w_dec.mem_size = w_f3[1:0]; w_dec.mem_unsigned = w_f3[2];
        w_dec.illegal = (w_f3[1:0] == 2'b11) || (w_f3 == 3'b110);
      end
      OP_STORE: begin
        w_dec.mem_we = 1'b1; w_dec.sext_op = 3'b010;
        w_dec.rs1_re = 1'b1; w_dec.rs2_re = 1'b1; w_dec.mem_size = w_f3[1:0];
        w_dec.illegal = w_f3[2] || (w_f3[1:0] == 2'b11);
      end
      OP_IMM: begin
        w_dec.reg_we = 1'b1; w_dec.sext_op = 3'b001; w_dec.rs1_re = 1'b1;
        // Bit 30 of an immediate is data except in srai.
        w_dec.alu_ctrl = alu_of(w_f3, (w_f3 == 3'b101) && w_alt);
      end
      OP_REG: begin
        w_dec.reg_we = 1'b1; w_dec.op_b_sel = 1'b1;
        w_dec.rs1_re = 1'b1; w_dec.rs2_re = 1'b1;
        w_dec.alu_ctrl = alu_of(w_f3, w_alt);
      end
      // fence and ecall/ebreak flow through as side-effect-free no-ops.
      OP_FENCE:  w_dec.illegal = (w_f3 != 3'b000);
      OP_SYSTEM: w_dec.illegal = (w_f3 != 3'b000);
      default:   w_dec.illegal = 1'b1;
    endcase
    // Undecodable words must not write, touch memory, redirect or stall.
    if (w_dec.illegal) begin
      w_dec.reg_we = 1'b0; w_dec.mem_re = 1'b0; w_dec.mem_we = 1'b0;
      w_dec.branch = 1'b0; w_dec.rs1_re = 1'b0; w_dec.rs2_re = 1'b0;
    end
  end

  // Bundle as loaded on a normal advance: effects qualified by in_valid.
  always_comb begin
    w_load         = w_dec;
    w_load.reg_we  = w_dec.reg_we  & bus.in_valid;
    w_load.mem_re  = w_dec.mem_re  & bus.in_valid;
    w_load.mem_we  = w_dec.mem_we  & bus.in_valid;
    w_load.branch  = w_dec.branch  & bus.in_valid;
    w_load.illegal = w_dec.illegal & bus.in_valid;
  end

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    w_hazard = LOAD_USE_DETECT && r_out_valid && r_ctrl.mem_re &&
               (r_ctrl.rd != 5'd0) && bus.in_valid &&
               ((w_dec.rs1_re && (w_dec.rs1 == r_ctrl.rd)) ||
                (w_dec.rs2_re && (w_dec.rs2 == r_ctrl.rd)));
  end

  assign bus.stall_if = bus.ex_stall | (w_hazard & ~bus.flush);

  // ID/EX register: flush > hold > bubble > advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl       <= '0;
      r_out_valid  <= 1'b0;
      r_out_pc     <= '0;
      r_bubble_cnt <= '0;
    end else if (bus.flush) begin
      r_out_valid   <= 1'b0;
      r_ctrl.reg_we <= 1'b0;
      r_ctrl.mem_re <= 1'b0;
      r_ctrl.mem_we <= 1'b0;
      r_ctrl.branch <= 1'b0;
    end else if (!bus.ex_stall) begin
      if (w_hazard) begin
        r_out_valid   <= 1'b0;
        r_ctrl.reg_we <= 1'b0;
        r_ctrl.mem_re <= 1'b0;
        r_ctrl.mem_we <= 1'b0;
        r_ctrl.branch <= 1'b0;
        if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end else begin
        r_ctrl      <= w_load;
        r_out_valid <= bus.in_valid;
        r_out_pc    <= bus.in_pc;
      end
    end
  end

  assign bus.out_valid    = r_out_valid;
  assign bus.out_pc       = r_out_pc;
  assign bus.rs1          = r_ctrl.rs1;
  assign bus.rs2          = r_ctrl.rs2;
  assign bus.rd           = r_ctrl.rd;
  assign bus.rs1_re       = r_ctrl.rs1_re;
  assign bus.rs2_re       = r_ctrl.rs2_re;
  assign bus.reg_we       = r_ctrl.reg_we;
  assign bus.wb_sel       = r_ctrl.wb_sel;
  assign bus.pc_sel       = r_ctrl.pc_sel;
  assign bus.branch       = r_ctrl.branch;
  assign bus.mem_re       = r_ctrl.mem_re;
  assign bus.mem_we       = r_ctrl.mem_we;
  assign bus.mem_size     = r_ctrl.mem_size;
  assign bus.mem_unsigned = r_ctrl.mem_unsigned;
  assign bus.alu_ctrl     = r_ctrl.alu_ctrl;
  assign bus.op_a_sel     = r_ctrl.op_a_sel;
  assign bus.op_b_sel     = r_ctrl.op_b_sel;
  assign bus.sext_op      = r_ctrl.sext_op;
  assign bus.illegal      = r_ctrl.illegal;
  assign bus.bubble_cnt   = r_bubble_cnt;
endmodule
